// File: rtl/pio_event_master.sv
// Avalon-MM master for an edge-capturing PIO slave: programs its IRQ mask, then on
// each IRQ reads/clears edge capture, reads the live level and queues {edges, level}.
module pio_event_master #(
  parameter int               WIDTH    = 2,
  parameter logic [WIDTH-1:0] IRQ_MASK = 2'b11,
  parameter int               DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic             overflow,
  output logic [7:0]       drop_count,
  output logic [2:0]       fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_RD_EDGE  = 3'd2;
  localparam logic [2:0] S_CLR_EDGE = 3'd3;
  localparam logic [2:0] S_RD_DATA  = 3'd4;
  localparam logic [2:0] S_CAP_DATA = 3'd5;

  logic [2:0]         state;
  logic [WIDTH-1:0]   edge_reg;
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;
  logic unused_rd;

  assign unused_rd = ^avm_readdata[31:WIDTH];
  assign fsm_state = state;

  // Bus outputs decode straight from state; reset forces them idle so an aborted
  // sequence issues no further cycles.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 2'd0;
    avm_writedata  = 32'd0;
    if (!reset) begin
      case (state)
        S_INIT: begin
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_address    = 2'd2;
          avm_writedata  = {{(32-WIDTH){1'b0}}, IRQ_MASK};
        end
        S_RD_EDGE: begin
          avm_chipselect = 1'b1;
          avm_address    = 2'd3;
        end
        S_CLR_EDGE: begin
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_address    = 2'd3;
        end
        S_RD_DATA: begin
          avm_chipselect = 1'b1;
          avm_address    = 2'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      edge_reg <= '0;
    end else begin
      case (state)
        S_INIT:     state <= S_IDLE;
        S_IDLE:     if (irq && enable) state <= S_RD_EDGE;
        S_RD_EDGE:  state <= S_CLR_EDGE;
        S_CLR_EDGE: begin
          edge_reg <= avm_readdata[WIDTH-1:0];
          state    <= S_RD_DATA;
        end
        S_RD_DATA:  state <= S_CAP_DATA;
        S_CAP_DATA: state <= S_IDLE;
        default:    state <= S_INIT;
      endcase
    end
  end

  // A zero edge value means a spurious IRQ: neither pushed nor counted as a drop.
  assign push_req = (state == S_CAP_DATA) && (edge_reg != '0);
  assign evt_valid = (count != '0);
  assign pop      = evt_valid && evt_ready;
  assign full     = (count == FULL_CNT);
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign evt_edges = mem[rd_ptr][2*WIDTH-1:WIDTH];
  assign evt_level = mem[rd_ptr][WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {edge_reg, avm_readdata[WIDTH-1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hff) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule
